// File: rtl/fp_rnd_pipe_pkg.sv
// Shared types and constants for the single-precision rounding/packing pipeline.
// Producers fill fp_rnd_in_type; fp_rnd_core turns it into the stage-1 record.
package fp_wire;

  typedef struct packed {
    logic        sig;
    logic [9:0]  expo;
    logic [24:0] mant;
    logic [1:0]  rema;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [2:0]  grs;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        inf;
    logic        zero;
  } fp_rnd_in_type;

  typedef struct packed {
    logic snan;
    logic qnan;
    logic dbz;
    logic inf;
    logic zero;
  } fp_rnd_special_type;

  typedef struct packed {
    logic               sig;
    logic [9:0]         expo;
    logic [23:0]        mant;
    logic               inexact;
    logic               tiny;
    logic [2:0]         rm;
    fp_rnd_special_type specials;
  } fp_rnd_pipe_s1_type;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
  localparam logic [31:0] MAXF32 = 32'h7F7F_FFFF;

  // Reserved rounding-mode encodings fall back to round-to-nearest-even.
  function automatic logic round_up(input logic [2:0] rm, input logic sig, input logic lsb,
                                    input logic g, input logic r, input logic s);
    logic inc;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sig & (g | r | s);
      RM_RUP:  inc = ~sig & (g | r | s);
      RM_RMM:  inc = g;
      default: inc = g & (lsb | r | s);
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fp_rnd_pipe_core.sv
// Combinational stage-1 rounding: subnormal denormalisation, increment and carry
// renormalisation. Usable on its own by callers that do not need the pipeline.
module fp_rnd_core
  import fp_wire::*;
(
  input  fp_rnd_in_type      rnd_i,
  output fp_rnd_pipe_s1_type s1_o
);

  logic signed [10:0] shift_raw;
  logic [4:0]         shamt;
  logic [26:0]        full;
  logic [26:0]        shifted;
  logic [26:0]        lost_mask;
  logic [23:0]        mant_sh;
  logic [24:0]        sum;
  logic               denorm;
  logic               g;
  logic               r;
  logic               s;
  logic               inc;
  logic               inc_u;
  logic               unused_in;

  assign unused_in = ^{rnd_i.rema, rnd_i.fmt, rnd_i.mant[24]};

  always_comb begin
    denorm    = $signed(rnd_i.expo) <= 10'sd0;
    shift_raw = 11'sd1 - $signed({rnd_i.expo[9], rnd_i.expo});
    shamt     = 5'd0;
    if (denorm) shamt = (shift_raw > 11'sd26) ? 5'd26 : shift_raw[4:0];

    full      = {rnd_i.mant[23:0], rnd_i.grs};
    shifted   = full >> shamt;
    lost_mask = ~({27{1'b1}} << shamt);
    mant_sh   = shifted[26:3];
    g         = shifted[2];
    r         = shifted[1];
    s         = shifted[0] | (|(full & lost_mask));

    inc = round_up(rnd_i.rm, rnd_i.sig, mant_sh[0], g, r, s);
    sum = {1'b0, mant_sh} + {24'd0, inc};
    // Tininess uses the unbounded-exponent rounding: only 0xFFFFFF at expo 0 can escape it.
    inc_u = round_up(rnd_i.rm, rnd_i.sig, rnd_i.mant[0], rnd_i.grs[2], rnd_i.grs[1], rnd_i.grs[0]);

    s1_o          = '0;
    s1_o.sig      = rnd_i.sig;
    s1_o.rm       = rnd_i.rm;
    s1_o.inexact  = g | r | s;
    s1_o.tiny     = denorm & ~((rnd_i.expo == 10'd0) && (rnd_i.mant[23:0] == 24'hFF_FFFF) && inc_u);
    s1_o.specials = '{snan: rnd_i.snan, qnan: rnd_i.qnan, dbz: rnd_i.dbz,
                      inf: rnd_i.inf, zero: rnd_i.zero};
    s1_o.expo     = denorm ? 10'd0 : rnd_i.expo;
    if (sum[24]) begin
      s1_o.mant = 24'h80_0000;
      s1_o.expo = rnd_i.expo + 10'd1;
    end else begin
      s1_o.mant = sum[23:0];
      if (denorm && sum[23]) s1_o.expo = 10'd1;
    end
  end

endmodule

// File: rtl/fp_rnd_pipe.sv
// Two-stage rounding/packing pipeline: stage 1 rounds, stage 2 resolves specials and
// packs binary32 plus fflags. The whole pipe stalls together on output backpressure.
module fp_rnd_pipe
  import fp_wire::*;
#(
  parameter int REG_OUT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          valid_i,
  output logic          ready_o,
  input  fp_rnd_in_type fp_rnd_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [31:0]   result,
  output logic [4:0]    flags
);

  fp_rnd_pipe_s1_type core_s1;
  fp_rnd_pipe_s1_type s1_d;
  fp_rnd_pipe_s1_type s1_q;
  logic               s1_valid_d;
  logic               s1_valid_q;
  logic               adv;
  logic               overflow;
  logic               to_inf;
  logic [31:0]        pack_result;
  logic [4:0]         pack_flags;
  logic               unused_s1;

  assign unused_s1 = s1_q.mant[23];

  fp_rnd_core u_core (
    .rnd_i (fp_rnd_i),
    .s1_o  (core_s1)
  );

  always_comb begin
    adv        = ~valid_o | ready_i;
    ready_o    = adv & ~clear;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (clear) begin
      s1_valid_d = 1'b0;
    end else if (adv) begin
      s1_valid_d = valid_i;
      s1_d       = core_s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  always_comb begin
    overflow    = $signed(s1_q.expo) >= 10'sd255;
    to_inf      = (s1_q.rm == RM_RNE) || (s1_q.rm == RM_RMM) || (s1_q.rm > RM_RMM) ||
                  ((s1_q.rm == RM_RUP) && !s1_q.sig) || ((s1_q.rm == RM_RDN) && s1_q.sig);
    pack_result = '0;
    pack_flags  = '0;
    if (s1_q.specials.snan) begin
      pack_result         = QNAN32;
      pack_flags[FLAG_NV] = 1'b1;
    end else if (s1_q.specials.qnan) begin
      pack_result = QNAN32;
    end else if (s1_q.specials.dbz) begin
      pack_result         = {s1_q.sig, 8'hFF, 23'd0};
      pack_flags[FLAG_DZ] = 1'b1;
    end else if (s1_q.specials.inf) begin
      pack_result = {s1_q.sig, 8'hFF, 23'd0};
    end else if (s1_q.specials.zero) begin
      pack_result = {s1_q.sig, 31'd0};
    end else if (overflow) begin
      pack_result         = to_inf ? {s1_q.sig, 8'hFF, 23'd0} : {s1_q.sig, MAXF32[30:0]};
      pack_flags[FLAG_OF] = 1'b1;
      pack_flags[FLAG_NX] = 1'b1;
    end else begin
      // Subnormals arrive with expo already 0, so one packing covers both cases.
      pack_result         = {s1_q.sig, s1_q.expo[7:0], s1_q.mant[22:0]};
      pack_flags[FLAG_NX] = s1_q.inexact;
      pack_flags[FLAG_UF] = s1_q.inexact & s1_q.tiny;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic        out_valid_d;
      logic        out_valid_q;
      logic [31:0] result_d;
      logic [31:0] result_q;
      logic [4:0]  flags_d;
      logic [4:0]  flags_q;

      always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (clear) begin
          out_valid_d = 1'b0;
        end else if (adv) begin
          out_valid_d = s1_valid_q;
          result_d    = pack_result;
          flags_d     = pack_flags;
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          out_valid_q <= 1'b0;
          result_q    <= '0;
          flags_q     <= '0;
        end else begin
          out_valid_q <= out_valid_d;
          result_q    <= result_d;
          flags_q     <= flags_d;
        end
      end

      assign valid_o = out_valid_q;
      assign result  = result_q;
      assign flags   = flags_q;
    end else begin : g_comb_out
      assign valid_o = s1_valid_q;
      assign result  = pack_result;
      assign flags   = pack_flags;
    end
  endgenerate

endmodule
